// File: rtl/outputc_if.sv
// ----------------------------------------------------------------------------
// outputc_pkg / outputc_if
// Purpose : Shared flit type and the crossbar-side bundle between the input
//           channels and one router output channel.
//
// outputc_pkg
//   PORT_N    number of input channels competing for this output
//   VCH       highest virtual-channel index (VCH+1 VCs)
//   DATAW     flit data is data[DATAW:0]
//   TYPE_*    flit type field data[TYPE_MSB:TYPE_LSB]
//   router_i_t  {data, valid, vch}
//
// outputc_if signals
//   req   [PORT_N]            input channel i requests this output
//   flit  [PORT_N]router_i_t  flit offered by input channel i
//   grt   [PORT_N]            one-hot grant back to the input channels
//   lck                       output owned by a packet
// Modports: master = input-channel side, slave = output channel.
// ----------------------------------------------------------------------------
package outputc_pkg;
   localparam int PORT_N   = 5;
   localparam int VCH      = 1;
   localparam int VCW      = (VCH > 0) ? $clog2(VCH + 1) : 1;
   localparam int DATAW    = 31;
   localparam int TYPE_MSB = DATAW;
   localparam int TYPE_LSB = DATAW - 2;

   localparam logic [2:0] TYPE_NONE     = 3'd0;
   localparam logic [2:0] TYPE_HEAD     = 3'd1;
   localparam logic [2:0] TYPE_BODY     = 3'd2;
   localparam logic [2:0] TYPE_TAIL     = 3'd3;
   localparam logic [2:0] TYPE_HEADTAIL = 3'd4;

   typedef struct packed {
      logic [DATAW:0] data;
      logic           valid;
      logic [VCW-1:0] vch;
   } router_i_t;
endpackage

interface outputc_if;
   import outputc_pkg::*;

   logic      [PORT_N-1:0] req;
   router_i_t [PORT_N-1:0] flit;
   logic      [PORT_N-1:0] grt;
   logic                   lck;

   modport master (output req, output flit, input grt, input lck);
   modport slave  (input req, input flit, output grt, output lck);
endinterface

// File: rtl/outputc.sv
// ----------------------------------------------------------------------------
// outputc
// Purpose : Output channel of one router physical port. Round-robin arbitrates
//           the input channels, holds the grant for a whole packet, tracks
//           per-VC credits for the neighbour's input FIFOs and registers each
//           accepted flit onto the link.
//
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   xbar      outputc_if.slave : req/flit in, grt/lck out (both registered)
//   credit_i  [VCH:0]  one-cycle pulse per VC, neighbour freed one slot
//   rdy_o     [VCH:0]  credit[v] != 0 (combinational from the counters)
//   link_o    router_i_t registered flit to the neighbour
//
// Optional feature (macro OUTPUTC_STATS_EN):
//   flit_cnt_o[31:0]   accepted flits
//   stall_cnt_o[31:0]  locked cycles with a valid flit blocked on zero credit
//   ovf_o              sticky: credit pulse arrived with the counter full
// ----------------------------------------------------------------------------
module outputc
   import outputc_pkg::*;
#(
   parameter int ROUTERID = 0,
   parameter int PCHID    = 0,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   outputc_if.slave     xbar,
   input  logic [VCH:0] credit_i,
   output logic [VCH:0] rdy_o,
`ifdef OUTPUTC_STATS_EN
   output logic [31:0]  flit_cnt_o,
   output logic [31:0]  stall_cnt_o,
   output logic         ovf_o,
`endif
   output router_i_t    link_o
);

   localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CRED_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PORT_N-1:0] GRT_ONE  = {{(PORT_N-1){1'b0}}, 1'b1};

   // The debug indices only identify the instance; reject nonsense at elaboration.
   if (ROUTERID < 0 || PCHID < 0 || DEPTH < 1) begin : g_param_chk
      $error("outputc: ROUTERID/PCHID must be >= 0 and DEPTH >= 1");
   end

   // Round-robin pick: first requester at or after (ptr+1) mod PORT_N.
   // Returns {found, index}. Scanning from the far end lets the nearest
   // requester overwrite the result last.
   function automatic logic [PTR_W:0] rr_pick(input logic [PORT_N-1:0] req,
                                              input logic [PTR_W-1:0]  ptr);
      logic [PTR_W:0] res;
      int             idx;
      res = '0;
      for (int k = PORT_N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % PORT_N;
         if (req[idx]) begin
            res = {1'b1, PTR_W'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Registers
   logic [0:0]                 state_q,  state_d;
   logic [PTR_W-1:0]           ptr_q,    ptr_d;
   logic [PORT_N-1:0]          grt_q,    grt_d;
   logic [VCH:0][CNT_W-1:0]    credit_q, credit_d;
   router_i_t                  link_q,   link_d;

   // Combinational helpers
   router_i_t                  sel_flit_s;
   logic [2:0]                 sel_type_s;
   logic                       sel_cred_ok_s;
   logic                       accept_s;
   logic                       is_last_s;
   logic [VCH:0]               vc_dec_s;
   logic [PTR_W:0]             pick_s;

   // Mux the flit of the current owner; ptr_q holds the last winner.
   always_comb begin
      sel_flit_s = '0;
      for (int p = 0; p < PORT_N; p++) begin
         if (ptr_q == PTR_W'(p)) begin
            sel_flit_s = xbar.flit[p];
         end else begin
            sel_flit_s = sel_flit_s;
         end
      end
   end

   assign sel_type_s = sel_flit_s.data[TYPE_MSB:TYPE_LSB];
   assign is_last_s  = (sel_type_s == TYPE_TAIL) || (sel_type_s == TYPE_HEADTAIL);

   // Credit availability for the owner's VC; compared per VC so an encoded
   // vch beyond VCH simply has no credit.
   always_comb begin
      sel_cred_ok_s = 1'b0;
      for (int v = 0; v <= VCH; v++) begin
         if (sel_flit_s.vch == VCW'(v)) begin
            sel_cred_ok_s = (credit_q[v] != '0);
         end else begin
            sel_cred_ok_s = sel_cred_ok_s;
         end
      end
   end

   // A TYPE_NONE flit is dropped: never accepted, never charged a credit.
   assign accept_s = (state_q == ST_LOCKED) && sel_flit_s.valid &&
                     (sel_type_s != TYPE_NONE) && sel_cred_ok_s;

   // Per-VC decrement strobe from the single accepted flit.
   always_comb begin
      vc_dec_s = '0;
      for (int v = 0; v <= VCH; v++) begin
         vc_dec_s[v] = accept_s && (sel_flit_s.vch == VCW'(v));
      end
   end

   assign pick_s = rr_pick(xbar.req, ptr_q);

   // Arbitration / packet-lock state machine.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grt_d   = grt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_s[PTR_W]) begin
               state_d = ST_LOCKED;
               ptr_d   = pick_s[PTR_W-1:0];
               grt_d   = GRT_ONE << pick_s[PTR_W-1:0];
            end else begin
               grt_d   = '0;
            end
         end
         ST_LOCKED: begin
            // The lock is held even if req drops; only an accepted tail frees it.
            if (accept_s && is_last_s) begin
               state_d = ST_IDLE;
               grt_d   = '0;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grt_d   = '0;
         end
      endcase
   end

   // Credit counters: decrement on accept, increment on a credit pulse,
   // both together cancel; a pulse at full credit is dropped.
   always_comb begin
      credit_d = credit_q;
      for (int v = 0; v <= VCH; v++) begin
         if (vc_dec_s[v] && credit_i[v]) begin
            credit_d[v] = credit_q[v];
         end else if (vc_dec_s[v]) begin
            credit_d[v] = credit_q[v] - CRED_ONE;
         end else if (credit_i[v] && (credit_q[v] != CRED_FULL)) begin
            credit_d[v] = credit_q[v] + CRED_ONE;
         end else begin
            credit_d[v] = credit_q[v];
         end
      end
   end

   // Link register input: accepted flit, otherwise an all-zero bubble.
   always_comb begin
      if (accept_s) begin
         link_d       = sel_flit_s;
         link_d.valid = 1'b1;
      end else begin
         link_d       = '0;
      end
   end

   // State, grant, pointer, credit and link registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grt_q   <= '0;
         link_q  <= '0;
         for (int v = 0; v <= VCH; v++) begin
            credit_q[v] <= CRED_FULL;
         end
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grt_q    <= grt_d;
         link_q   <= link_d;
         credit_q <= credit_d;
      end
   end

   // Ready flags straight from the registered counters.
   always_comb begin
      rdy_o = '0;
      for (int v = 0; v <= VCH; v++) begin
         rdy_o[v] = (credit_q[v] != '0);
      end
   end

   assign xbar.grt = grt_q;
   assign xbar.lck = (state_q == ST_LOCKED);
   assign link_o   = link_q;

`ifdef OUTPUTC_STATS_EN
   logic [31:0] flit_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        ovf_q;
   logic        stall_s;
   logic        ovf_evt_s;

   assign stall_s = (state_q == ST_LOCKED) && sel_flit_s.valid &&
                    (sel_type_s != TYPE_NONE) && !sel_cred_ok_s;

   // Overflow event: a credit pulse that could not be applied because the
   // counter was already full and nothing was consumed that cycle.
   always_comb begin
      ovf_evt_s = 1'b0;
      for (int v = 0; v <= VCH; v++) begin
         if (credit_i[v] && !vc_dec_s[v] && (credit_q[v] == CRED_FULL)) begin
            ovf_evt_s = 1'b1;
         end else begin
            ovf_evt_s = ovf_evt_s;
         end
      end
   end

   // Statistics counters; free-running, wrap at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flit_cnt_q  <= 32'd0;
         stall_cnt_q <= 32'd0;
         ovf_q       <= 1'b0;
      end else begin
         flit_cnt_q  <= flit_cnt_q  + (accept_s ? 32'd1 : 32'd0);
         stall_cnt_q <= stall_cnt_q + (stall_s  ? 32'd1 : 32'd0);
         ovf_q       <= ovf_q | ovf_evt_s;
      end
   end

   assign flit_cnt_o  = flit_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
   assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_outputc.sv
// ----------------------------------------------------------------------------
// tb_outputc : directed self-checking bench for outputc (DEPTH=4, PORT_N=5,
// two VCs). Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point, so each check sees the result of the edge just
// taken.
// ----------------------------------------------------------------------------
module tb_outputc;
   import outputc_pkg::*;

   logic         clk;
   logic         rst_n;
   logic [VCH:0] credit_i;
   logic [VCH:0] rdy_o;
   router_i_t    link_o;
`ifdef OUTPUTC_STATS_EN
   logic [31:0]  flit_cnt;
   logic [31:0]  stall_cnt;
   logic         ovf;
`endif

   int pass_cnt;
   int chk_cnt;

   outputc_if bus ();

   outputc #(.ROUTERID(0), .PCHID(0), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .xbar     (bus),
      .credit_i (credit_i),
      .rdy_o    (rdy_o),
`ifdef OUTPUTC_STATS_EN
      .flit_cnt_o  (flit_cnt),
      .stall_cnt_o (stall_cnt),
      .ovf_o       (ovf),
`endif
      .link_o   (link_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic router_i_t mk(input logic [2:0] t, input logic [28:0] pl,
                                    input logic [VCW-1:0] vc);
      router_i_t f;
      f.data  = {t, pl};
      f.valid = 1'b1;
      f.vch   = vc;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req  = '0;
      bus.flit = '0;
      credit_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      chk_cnt++; if (bus.grt !== 5'b00000) $display("FAIL reset_grt got %b want 00000", bus.grt); else pass_cnt++;
      chk_cnt++; if (bus.lck !== 1'b0) $display("FAIL reset_lck got %b want 0", bus.lck); else pass_cnt++;
      chk_cnt++; if (link_o !== '0) $display("FAIL reset_link got %h want 0", link_o); else pass_cnt++;
      chk_cnt++; if (rdy_o !== 2'b11) $display("FAIL reset_rdy got %b want 11", rdy_o); else pass_cnt++;
      chk_cnt++; if (dut.credit_q[0] !== 3'd4 || dut.credit_q[1] !== 3'd4)
         $display("FAIL reset_credit got %0d/%0d want 4/4", dut.credit_q[0], dut.credit_q[1]); else pass_cnt++;
      rst_n = 1'b1;
   endtask

   task automatic test_single_packet();
      router_i_t f;
      do_reset();
      bus.req = 5'b00010;
      tick();
      chk_cnt++; if (bus.grt !== 5'b00010 || bus.lck !== 1'b1)
         $display("FAIL single_grant got grt=%b lck=%b want 00010/1", bus.grt, bus.lck); else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         f = mk((k == 0) ? TYPE_HEAD : ((k == 1) ? TYPE_BODY : TYPE_TAIL), 29'(16 + k), 1'b0);
         bus.flit[1] = f;
         tick();
         chk_cnt++; if (link_o !== f) $display("FAIL single_link%0d got %h want %h", k, link_o, f); else pass_cnt++;
      end
      chk_cnt++; if (bus.grt !== 5'b00000 || bus.lck !== 1'b0)
         $display("FAIL single_release got grt=%b lck=%b want 00000/0", bus.grt, bus.lck); else pass_cnt++;
      chk_cnt++; if (dut.credit_q[0] !== 3'd1) $display("FAIL single_credit got %0d want 1", dut.credit_q[0]); else pass_cnt++;
      clear_inputs();
      tick();
      chk_cnt++; if (link_o.valid !== 1'b0 || link_o.data !== 32'd0)
         $display("FAIL single_bubble got %h want 0", link_o); else pass_cnt++;
   endtask

   // After reset ptr=0, so the scan starts at 1 and port 2 wins first.
   task automatic test_round_robin();
      router_i_t f0, f2;
      int        exp_port;
      do_reset();
      f0 = mk(TYPE_HEADTAIL, 29'h100, 1'b1);
      f2 = mk(TYPE_HEADTAIL, 29'h200, 1'b1);
      bus.req     = 5'b00101;
      bus.flit[0] = f0;
      bus.flit[2] = f2;
      for (int p = 0; p < 4; p++) begin
         exp_port = (p % 2 == 0) ? 2 : 0;
         tick();
         chk_cnt++; if (bus.grt !== (5'b00001 << exp_port))
            $display("FAIL rr_grant%0d got %b want port %0d", p, bus.grt, exp_port); else pass_cnt++;
         tick();
         chk_cnt++; if (link_o !== ((exp_port == 2) ? f2 : f0) || bus.grt !== 5'b00000)
            $display("FAIL rr_link%0d got %h grt=%b want port %0d flit, grt 0", p, link_o, bus.grt, exp_port); else pass_cnt++;
      end
      clear_inputs();
   endtask

   task automatic test_credit_stall();
      router_i_t f;
      do_reset();
      bus.req = 5'b01000;
      tick();
      chk_cnt++; if (bus.grt !== 5'b01000) $display("FAIL stall_grant got %b want 01000", bus.grt); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         f = mk((k == 0) ? TYPE_HEAD : TYPE_BODY, 29'(k), 1'b0);
         bus.flit[3] = f;
         tick();
         chk_cnt++; if (link_o !== f) $display("FAIL stall_send%0d got %h want %h", k, link_o, f); else pass_cnt++;
      end
      chk_cnt++; if (rdy_o !== 2'b10) $display("FAIL stall_rdy got %b want 10", rdy_o); else pass_cnt++;
      f = mk(TYPE_BODY, 29'd4, 1'b0);
      bus.flit[3] = f;
      tick();
      tick();
      chk_cnt++; if (link_o.valid !== 1'b0 || bus.lck !== 1'b1)
         $display("FAIL stall_hold got valid=%b lck=%b want 0/1", link_o.valid, bus.lck); else pass_cnt++;
`ifdef OUTPUTC_STATS_EN
      chk_cnt++; if (stall_cnt !== 32'd2) $display("FAIL stall_cnt got %0d want 2", stall_cnt); else pass_cnt++;
`endif
      credit_i = 2'b01;
      tick();
      credit_i = 2'b00;
      chk_cnt++; if (link_o.valid !== 1'b0 || rdy_o !== 2'b11)
         $display("FAIL stall_credit got valid=%b rdy=%b want 0/11", link_o.valid, rdy_o); else pass_cnt++;
      tick();
      chk_cnt++; if (link_o !== f) $display("FAIL stall_resume got %h want %h", link_o, f); else pass_cnt++;
      chk_cnt++; if (rdy_o !== 2'b10) $display("FAIL stall_rdy2 got %b want 10", rdy_o); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_credit_edges();
      router_i_t f;
      do_reset();
      bus.req = 5'b00001;
      tick();
      f = mk(TYPE_HEAD, 29'h55, 1'b0);
      bus.flit[0] = f;
      credit_i    = 2'b01;
      tick();
      chk_cnt++; if (link_o !== f) $display("FAIL edge_accept got %h want %h", link_o, f); else pass_cnt++;
      chk_cnt++; if (dut.credit_q[0] !== 3'd4) $display("FAIL edge_simul got %0d want 4", dut.credit_q[0]); else pass_cnt++;
      bus.flit = '0;
      tick();
      credit_i = 2'b00;
      chk_cnt++; if (dut.credit_q[0] !== 3'd4) $display("FAIL edge_full got %0d want 4", dut.credit_q[0]); else pass_cnt++;
`ifdef OUTPUTC_STATS_EN
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL edge_ovf got %b want 1", ovf); else pass_cnt++;
`endif
      bus.req = 5'b00000;
      tick();
      chk_cnt++; if (bus.lck !== 1'b1 || bus.grt !== 5'b00001)
         $display("FAIL edge_reqdrop got lck=%b grt=%b want 1/00001", bus.lck, bus.grt); else pass_cnt++;
      bus.flit[0] = mk(TYPE_NONE, 29'h77, 1'b0);
      tick();
      chk_cnt++; if (link_o.valid !== 1'b0 || dut.credit_q[0] !== 3'd4 || bus.lck !== 1'b1)
         $display("FAIL edge_none got valid=%b cred=%0d lck=%b want 0/4/1", link_o.valid, dut.credit_q[0], bus.lck); else pass_cnt++;
      f = mk(TYPE_TAIL, 29'h66, 1'b0);
      bus.flit[0] = f;
      tick();
      chk_cnt++; if (link_o !== f || bus.lck !== 1'b0 || dut.credit_q[0] !== 3'd3)
         $display("FAIL edge_tail got %h lck=%b cred=%0d want %h/0/3", link_o, bus.lck, dut.credit_q[0], f); else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      bus.req = 5'b10000;
      tick();
      bus.flit[4] = mk(TYPE_HEAD, 29'h9, 1'b1);
      tick();
      chk_cnt++; if (link_o.valid !== 1'b1 || dut.credit_q[1] !== 3'd3)
         $display("FAIL mid_head got valid=%b cred=%0d want 1/3", link_o.valid, dut.credit_q[1]); else pass_cnt++;
      rst_n = 1'b0;
      tick();
      chk_cnt++; if (bus.lck !== 1'b0 || bus.grt !== 5'b00000 || link_o !== '0 || dut.credit_q[1] !== 3'd4)
         $display("FAIL mid_reset got lck=%b grt=%b link=%h cred=%0d want 0/0/0/4",
                  bus.lck, bus.grt, link_o, dut.credit_q[1]); else pass_cnt++;
      rst_n = 1'b1;
      clear_inputs();
      bus.req = 5'b00010;
      tick();
      chk_cnt++; if (bus.grt !== 5'b00010 || bus.lck !== 1'b1)
         $display("FAIL mid_regrant got grt=%b lck=%b want 00010/1", bus.grt, bus.lck); else pass_cnt++;
      clear_inputs();
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      rst_n    = 1'b0;
      clear_inputs();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_credit_stall();
      test_credit_edges();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
